// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared TAP state encoding, opcodes and data-register select type
//
// Purpose: common definitions for the JTAG TAP controller slice.
//   tap_state_t : 16-state TAP machine, 4-bit encoding
//   OPC_*       : instruction opcodes, 32 bits wide; truncate to IR width at the point of use
//   dr_sel_t    : which data register sits between tdi and tdo
package jtag_pkg;

  localparam int IR_W_DEF = 4;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_t;

  // BYPASS is all ones, so truncation to any IR width keeps it all ones.
  localparam logic [31:0] OPC_EXTEST = 32'h0000_0000;
  localparam logic [31:0] OPC_SAMPLE = 32'h0000_0001;
  localparam logic [31:0] OPC_IDCODE = 32'h0000_0002;
  localparam logic [31:0] OPC_BYPASS = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DR_BSC = 2'd0,
    DR_BYP = 2'd1,
    DR_ID  = 2'd2
  } dr_sel_t;

endpackage

// File: rtl/tap_fsm.sv
// rtl/tap_fsm.sv - 16-state TAP state machine driven by tms
//
// Purpose: state register and next-state decode only.
// Ports:
//   tck   in  : test clock, rising edge
//   rst   in  : synchronous active-high reset to TLR, overrides tms
//   tms   in  : test mode select
//   state out : current TAP state
module tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       rst,
  input  logic       tms,
  output tap_state_t state
);

  tap_state_t state_q;
  tap_state_t state_d;

  always_ff @(posedge tck) begin
    if (rst) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = TLR;
    case (state_q)
      TLR:     state_d = tms ? TLR    : RTI;
      RTI:     state_d = tms ? SEL_DR : RTI;
      SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
      SH_DR:   state_d = tms ? EX1_DR : SH_DR;
      EX1_DR:  state_d = tms ? UPD_DR : PAU_DR;
      PAU_DR:  state_d = tms ? EX2_DR : PAU_DR;
      EX2_DR:  state_d = tms ? UPD_DR : SH_DR;
      UPD_DR:  state_d = tms ? SEL_DR : RTI;
      SEL_IR:  state_d = tms ? TLR    : CAP_IR;
      CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
      SH_IR:   state_d = tms ? EX1_IR : SH_IR;
      EX1_IR:  state_d = tms ? UPD_IR : PAU_IR;
      PAU_IR:  state_d = tms ? EX2_IR : PAU_IR;
      EX2_IR:  state_d = tms ? UPD_IR : SH_IR;
      UPD_IR:  state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - TAP controller: IR, bypass/IDCODE registers, tdo mux, boundary chain controls
//
// Purpose: sequences the boundary-scan chain from the JTAG pins.
// Parameters:
//   IR_W       : instruction register width (at least 2)
//   IDCODE_VAL : value captured into the ID register (bit 0 set)
// Ports:
//   tck, rst       in  : test clock; synchronous active-high reset
//   tms, tdi       in  : JTAG mode select and serial data in
//   tdo, tdo_en    out : serial data out and its enable (SH_DR / SH_IR)
//   bsc_si         out : serial data into the chain (tdi)
//   bsc_so         in  : serial data out of the last chain cell
//   bsc_shift_dr   out : chain shift select
//   bsc_capture_en out : chain capture enable
//   bsc_update_en  out : chain update enable
//   bsc_mode       out : chain test-mux select (EXTEST active)
//   ir_out         out : current instruction
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int          IR_W       = IR_W_DEF,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic            tck,
  input  logic            rst,
  input  logic            tms,
  input  logic            tdi,
  output logic            tdo,
  output logic            tdo_en,
  output logic            bsc_si,
  input  logic            bsc_so,
  output logic            bsc_shift_dr,
  output logic            bsc_capture_en,
  output logic            bsc_update_en,
  output logic            bsc_mode,
  output logic [IR_W-1:0] ir_out
);

  localparam logic [IR_W-1:0] EXTEST  = IR_W'(OPC_EXTEST);
  localparam logic [IR_W-1:0] SAMPLE  = IR_W'(OPC_SAMPLE);
  localparam logic [IR_W-1:0] IDCODE  = IR_W'(OPC_IDCODE);
  // Fixed capture pattern: LSB pair 01 lets a board tester find IR boundaries.
  localparam logic [IR_W-1:0] IR_CAPT = IR_W'(1);

  tap_state_t      state;
  logic [IR_W-1:0] ir_sr;
  logic [IR_W-1:0] ir_reg;
  logic            byp_q;
  logic [31:0]     id_sr;
  dr_sel_t         dr_sel;
  logic            bsc_sel;

  tap_fsm u_fsm (
    .tck   (tck),
    .rst   (rst),
    .tms   (tms),
    .state (state)
  );

  // IR shift register and shadow. The shadow only changes in UPD_IR or TLR,
  // so the selected DR is stable for the whole of any DR scan.
  always_ff @(posedge tck) begin
    if (rst) begin
      ir_sr  <= '0;
      ir_reg <= IDCODE;
    end else begin
      case (state)
        CAP_IR:  ir_sr  <= IR_CAPT;
        SH_IR:   ir_sr  <= {tdi, ir_sr[IR_W-1:1]};
        UPD_IR:  ir_reg <= ir_sr;
        TLR:     ir_reg <= IDCODE;
        default: ;
      endcase
    end
  end

  // Bypass and ID registers run on every DR scan; only the selected one reaches tdo.
  always_ff @(posedge tck) begin
    if (rst) begin
      byp_q <= 1'b0;
      id_sr <= '0;
    end else begin
      case (state)
        CAP_DR: begin
          byp_q <= 1'b0;
          id_sr <= IDCODE_VAL;
        end
        SH_DR: begin
          byp_q <= tdi;
          id_sr <= {tdi, id_sr[31:1]};
        end
        default: ;
      endcase
    end
  end

  // Unknown opcodes fall through to bypass.
  always_comb begin
    dr_sel = DR_BYP;
    if (ir_reg == EXTEST || ir_reg == SAMPLE) begin
      dr_sel = DR_BSC;
    end else if (ir_reg == IDCODE) begin
      dr_sel = DR_ID;
    end
  end

  assign bsc_sel = (dr_sel == DR_BSC);

  always_comb begin
    tdo = 1'b0;
    if (state == SH_IR) begin
      tdo = ir_sr[0];
    end else if (state == SH_DR) begin
      case (dr_sel)
        DR_BSC:  tdo = bsc_so;
        DR_ID:   tdo = id_sr[0];
        default: tdo = byp_q;
      endcase
    end
  end

  assign tdo_en         = (state == SH_DR) || (state == SH_IR);
  assign bsc_si         = tdi;
  assign bsc_capture_en = bsc_sel && (state == CAP_DR);
  assign bsc_shift_dr   = bsc_sel && (state == SH_DR);
  assign bsc_update_en  = bsc_sel && (state == UPD_DR);
  assign bsc_mode       = (ir_reg == EXTEST);
  assign ir_out         = ir_reg;

endmodule
